// File: rtl/keypad_history_display.sv
// Purpose: keeps the last N_DIGITS key codes and time-multiplexes them onto a common-select seven-segment display.
// Latency: seg_out/digit_sel are registered one cycle behind the mux FSM and history; history_count follows the history register directly.
// Backpressure: none; every key_pulse is accepted, the oldest key is dropped when full, and clear overrides a same-cycle key.
module keypad_history_display #(
  parameter int N_DIGITS      = 4,
  parameter int REFRESH_DIV   = 12000,
  parameter int BLANK_CYCLES  = 16,
  parameter bit EMPTY_AS_ZERO = 1'b0
) (
  input  logic                            clk_internal,
  input  logic                            rst_n,
  input  logic [3:0]                      key_code,
  input  logic                            key_pulse,
  input  logic                            clear,
  output logic [6:0]                      seg_out,
  output logic [N_DIGITS-1:0]             digit_sel,
  output logic [$clog2(N_DIGITS+1)-1:0]   history_count
);

  // Widths: the phase counter must hold the longer of the two phases; the
  // digit index keeps at least one bit so a single-digit build still elaborates.
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_TOP = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int PH_W    = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;
  localparam int HC_W    = $clog2(N_DIGITS + 1);

  localparam logic [PH_W-1:0]     DRIVE_LAST = PH_W'(REFRESH_DIV - 1);
  localparam logic [PH_W-1:0]     BLANK_LAST = PH_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [HC_W-1:0]     HC_FULL    = HC_W'(N_DIGITS);
  localparam logic [N_DIGITS-1:0] SEL_ONE    = N_DIGITS'(1);

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_BLANK = 1'b1
  } mux_state_t;

  // Active-low {g,f,e,d,c,b,a} hex glyphs.
  function automatic logic [6:0] glyph(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // History storage: slot 0 is the newest key and maps to the rightmost digit.
  logic [3:0]          slot_dat [N_DIGITS];
  logic [N_DIGITS-1:0] slot_vld;

  // Mux FSM state.
  mux_state_t       state, state_nx;
  logic [PH_W-1:0]  phase_cnt, phase_nx;
  logic [IDX_W-1:0] digit_idx, idx_nx, idx_adv;

  // Next output values, registered below.
  logic [6:0]          seg_nx;
  logic [N_DIGITS-1:0] sel_nx;

  // Shift a new key into the history; clear takes priority and drops a same-cycle key.
  always_ff @(posedge clk_internal or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        slot_dat[i] <= 4'h0;
      end
      slot_vld      <= '0;
      history_count <= '0;
    end else if (clear) begin
      // Slot data is left stale on purpose; the valid flags alone hide it.
      slot_vld      <= '0;
      history_count <= '0;
    end else if (key_pulse) begin
      for (int i = N_DIGITS - 1; i > 0; i--) begin
        slot_dat[i] <= slot_dat[i-1];
        slot_vld[i] <= slot_vld[i-1];
      end
      slot_dat[0] <= key_code;
      slot_vld[0] <= 1'b1;
      if (history_count != HC_FULL) begin
        history_count <= history_count + HC_W'(1);
      end
    end
  end

  // Mux FSM state register.
  always_ff @(posedge clk_internal or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_DRIVE;
      phase_cnt <= '0;
      digit_idx <= '0;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_nx;
      digit_idx <= idx_nx;
    end
  end

  // Mux FSM next state: DRIVE for REFRESH_DIV cycles, then optional BLANK, then next digit.
  always_comb begin
    state_nx = state;
    phase_nx = phase_cnt + PH_W'(1);
    idx_nx   = digit_idx;
    idx_adv  = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    case (state)
      ST_DRIVE: begin
        if (phase_cnt == DRIVE_LAST) begin
          phase_nx = '0;
          if (BLANK_CYCLES > 0) begin
            state_nx = ST_BLANK;
          end else begin
            idx_nx = idx_adv;
          end
        end
      end
      ST_BLANK: begin
        if (phase_cnt == BLANK_LAST) begin
          phase_nx = '0;
          idx_nx   = idx_adv;
          state_nx = ST_DRIVE;
        end
      end
      default: begin
        state_nx = ST_DRIVE;
        phase_nx = '0;
        idx_nx   = '0;
      end
    endcase
  end

  // Output decode: one digit enabled while driving, everything dark while blanking.
  always_comb begin
    seg_nx = 7'h7F;
    sel_nx = '1;
    if (state == ST_DRIVE) begin
      sel_nx = ~(SEL_ONE << digit_idx);
      if (slot_vld[digit_idx]) begin
        seg_nx = glyph(slot_dat[digit_idx]);
      end else if (EMPTY_AS_ZERO) begin
        seg_nx = glyph(4'h0);
      end
    end
  end

  // Register the pins so they never glitch between digits.
  always_ff @(posedge clk_internal or negedge rst_n) begin
    if (!rst_n) begin
      seg_out   <= 7'h7F;
      digit_sel <= '1;
    end else begin
      seg_out   <= seg_nx;
      digit_sel <= sel_nx;
    end
  end

endmodule
